// File: rtl/flash_pkg.sv
// Shared constants for the serial-flash word reader: state codes and parameter defaults.
package flash_pkg;

    localparam int unsigned WORD_W_DEF   = 32;
    localparam logic [7:0]  READ_CMD_DEF = 8'h03;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCmd     = 3'd1;
    localparam logic [2:0] StAddr    = 3'd2;
    localparam logic [2:0] StData    = 3'd3;
    localparam logic [2:0] StDeliver = 3'd4;
    localparam logic [2:0] StDesel   = 3'd5;
    localparam logic [2:0] StHold    = 3'd6;

    // States in which the SPI clock runs.
    function automatic logic is_shifting(input logic [2:0] st);
        return (st == StCmd) || (st == StAddr) || (st == StData);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock divider: flash_clk toggles every CLK_DIV enabled cycles, with rise/fall strobes
// asserted in the clk cycle whose closing edge produces the matching flash_clk edge.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic sclk
);
    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    // Disabling parks the clock low and restarts the count, so every burst begins cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                sclk <= !sclk;
            end
        end
    end

endmodule

// File: rtl/flash_word_reader.sv
// SPI mode-0 flash read engine delivering one WORD_W word per fetch_en request.
// Define FLASH_CONT_READ_EN to keep the flash selected between words and skip CMD/ADDR.
module flash_word_reader
    import flash_pkg::*;
#(
    parameter int unsigned       WORD_W     = WORD_W_DEF,
    parameter int unsigned       ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int unsigned       CLK_DIV    = 2,
    parameter logic [7:0]        READ_CMD   = READ_CMD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              busy,
    output logic              flash_clk,
    output logic              flash_mosi,
    output logic              flash_csb,
    input  logic              flash_miso,
    input  logic              bypass_en,
    input  logic              host_mosi
);
    localparam int unsigned TX_W      = 8 + ADDR_W;
    localparam int unsigned MAX_BITS  = (WORD_W > ADDR_W) ? WORD_W : ADDR_W;
    localparam int unsigned CNT_W     = $clog2(MAX_BITS + 1);
    localparam int unsigned DESEL_CYC = 2 * CLK_DIV;
    localparam int unsigned DSL_W     = $clog2(DESEL_CYC);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DSL_W-1:0]  desel_q, desel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TX_W-1:0]   tx_q, tx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              ready_q, ready_d;
    logic              csb_q, csb_d;
    logic              div_en, spi_rise, spi_fall;

    assign div_en = is_shifting(state_q) && !bypass_en;

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk  (clk),
        .reset(reset),
        .en   (div_en),
        .rise (spi_rise),
        .fall (spi_fall),
        .sclk (flash_clk)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        desel_d   = desel_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        word_d    = word_q;
        ready_d   = 1'b0;

        // Next MOSI bit goes out on each falling edge.
        if (spi_fall) begin
            tx_d = tx_q << 1;
        end

        case (state_q)
            StIdle: begin
                if (fetch_en) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                    tx_d      = {READ_CMD, addr_q};
                end
            end
            StCmd: begin
                if (spi_rise) begin
                    if (bit_cnt_q == CNT_W'(7)) begin
                        state_d   = StAddr;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StAddr: begin
                if (spi_rise) begin
                    if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (spi_rise) begin
                    shift_d   = {shift_q[WORD_W-2:0], flash_miso};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (spi_fall && bit_cnt_q == CNT_W'(WORD_W)) begin
                    // Last bit captured and flash_clk is back low.
                    state_d   = StDeliver;
                    bit_cnt_d = '0;
                end
            end
            StDeliver: begin
                word_d  = shift_q;
                ready_d = 1'b1;
                addr_d  = addr_q + ADDR_W'(WORD_W / 8);
                desel_d = '0;
`ifdef FLASH_CONT_READ_EN
                state_d = StHold;
`else
                state_d = StDesel;
`endif
            end
            StDesel: begin
                desel_d = desel_q + 1'b1;
                if (desel_q == DSL_W'(DESEL_CYC - 1)) begin
                    state_d = StIdle;
                end
            end
`ifdef FLASH_CONT_READ_EN
            StHold: begin
                if (fetch_en) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        // Host pass-through wins: drop any partial transfer, keep addr and word.
        if (bypass_en) begin
            state_d = StIdle;
            addr_d  = addr_q;
            word_d  = word_q;
            ready_d = 1'b0;
        end

        csb_d = (state_d == StIdle) || (state_d == StDesel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            desel_q   <= '0;
            addr_q    <= START_ADDR;
            tx_q      <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            ready_q   <= 1'b0;
            csb_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            desel_q   <= desel_d;
            addr_q    <= addr_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            ready_q   <= ready_d;
            csb_q     <= csb_d;
        end
    end

    assign word       = word_q;
    assign word_ready = ready_q;
    assign flash_csb  = csb_q;
    assign busy       = !((state_q == StIdle) || (state_q == StHold));
    assign flash_mosi = bypass_en ? host_mosi
                      : (((state_q == StCmd) || (state_q == StAddr)) ? tx_q[TX_W-1] : 1'b0);

endmodule

// File: tb/tb_flash_word_reader.sv
// Bench for flash_word_reader: flash model returning byte = addr[7:0], cycle-level
// transaction model of the engine, directed scenarios plus randomized fetch/bypass traffic.
module tb_flash_word_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        flash_miso = 1'b0;
    logic        bypass_en = 1'b0;
    logic        host_mosi = 1'b0;
    logic [31:0] word;
    logic        word_ready, busy, flash_clk, flash_mosi, flash_csb;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    localparam int NEVER = 32'h7fff_ffff;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_word_reader dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_en  (fetch_en),
        .word      (word),
        .word_ready(word_ready),
        .busy      (busy),
        .flash_clk (flash_clk),
        .flash_mosi(flash_mosi),
        .flash_csb (flash_csb),
        .flash_miso(flash_miso),
        .bypass_en (bypass_en),
        .host_mosi (host_mosi)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [23:0] a);
        logic [23:0] a1, a2, a3;
        a1 = a + 24'd1;
        a2 = a + 24'd2;
        a3 = a + 24'd3;
        return {a[7:0], a1[7:0], a2[7:0], a3[7:0]};
    endfunction

    // Transaction-level model of the engine
    int          ready_at = -1;
    int          busy_until = -1;
    int          csb_low_until = -1;
    int          accept_from = 0;
    bit          hold = 1'b0;
    logic [23:0] exp_addr = 24'h0;
    logic [31:0] last_word = 32'h0;

    always @(negedge clk) begin
        if (!reset) begin
            ready_at      = -1;
            busy_until    = -1;
            csb_low_until = -1;
            accept_from   = 0;
            hold          = 1'b0;
            exp_addr      = 24'h0;
            last_word     = 32'h0;
        end else begin
            check("busy", 32'(busy), 32'(cyc <= busy_until));
            check("word_ready", 32'(word_ready), 32'(cyc == ready_at));
            check("csb", 32'(flash_csb), 32'(cyc > csb_low_until));
            if (cyc > csb_low_until) check("sclk_idle", 32'(flash_clk), 32'h0);
            if (bypass_en) check("mosi_bypass", 32'(flash_mosi), 32'(host_mosi));
            if (cyc == ready_at) begin
                last_word = word_at(exp_addr);
                exp_addr  = exp_addr + 24'd4;
            end
            check("word", word, last_word);

            if (bypass_en) begin
                ready_at = -1;
                if (busy_until > cyc) busy_until = cyc;
                if (csb_low_until > cyc) csb_low_until = cyc;
                hold        = 1'b0;
                accept_from = cyc + 1;
            end else if (fetch_en && cyc >= accept_from) begin
                if (hold) begin
                    ready_at      = cyc + 130;
                    busy_until    = ready_at - 1;
                    csb_low_until = NEVER;
                    accept_from   = ready_at;
                end else begin
                    ready_at = cyc + 258;
`ifdef FLASH_CONT_READ_EN
                    busy_until    = ready_at - 1;
                    csb_low_until = NEVER;
                    accept_from   = ready_at;
                    hold          = 1'b1;
`else
                    busy_until    = ready_at + 3;
                    csb_low_until = ready_at - 1;
                    accept_from   = ready_at + 4;
`endif
                end
            end
        end
    end

    // Flash device model
    int          nbits = 0;
    int          n_cmds = 0;
    logic [31:0] cap = 32'h0;
    logic [23:0] fl_addr = 24'h0;
    logic [23:0] last_addr = 24'hFFFFFF;
    logic [7:0]  last_cmd = 8'h00;

    always @(posedge flash_csb) nbits = 0;

    always @(posedge flash_clk) begin
        if (flash_csb === 1'b0) begin
            if (nbits < 32) cap = {cap[30:0], flash_mosi};
            nbits++;
            if (nbits == 32) begin
                last_cmd  = cap[31:24];
                last_addr = cap[23:0];
                fl_addr   = cap[23:0];
                n_cmds++;
                check("cmd_opcode", 32'(cap[31:24]), 32'h03);
                check("cmd_addr", 32'(cap[23:0]), 32'(exp_addr));
            end
        end
    end

    always @(negedge flash_clk) begin
        int          d;
        logic [23:0] ba;
        logic [7:0]  bv;
        if (flash_csb === 1'b0 && nbits >= 32) begin
            d  = nbits - 32;
            ba = fl_addr + 24'(d / 8);
            bv = ba[7:0];
            #1 flash_miso = bv[7 - (d % 8)];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fetch_and_wait(output logic [31:0] w, output int lat);
        int start;
        lat = -1;
        w   = 32'hDEAD_BEEF;
        tick(1);
        fetch_en = 1'b1;
        start    = cyc;
        tick(1);
        fetch_en = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (word_ready) begin
                lat = cyc - start;
                w   = word;
                break;
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        int          lat;
        int          n;

        tick(3);
        check("rst_csb", 32'(flash_csb), 32'h1);
        check("rst_sclk", 32'(flash_clk), 32'h0);
        check("rst_mosi", 32'(flash_mosi), 32'h0);
        check("rst_word", word, 32'h0);
        check("rst_ready", 32'(word_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        tick(5);

        fetch_and_wait(w, lat);
        check("lat_first", 32'(lat), 32'd258);
        check("word_first", w, 32'h0001_0203);
        check("cmd_first", 32'(last_cmd), 32'h03);
        check("addr_first", 32'(last_addr), 32'h0);
`ifndef FLASH_CONT_READ_EN
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("desel_csb", 32'(flash_csb), 32'h1);
        end
`else
        @(negedge clk);
        check("hold_csb", 32'(flash_csb), 32'h0);
`endif
        tick(10);
        fetch_and_wait(w, lat);
        check("word_second", w, 32'h0405_0607);
`ifdef FLASH_CONT_READ_EN
        check("lat_hold", 32'(lat), 32'd130);
        check("no_cmd_in_hold", 32'(n_cmds), 32'd1);
`else
        check("lat_second", 32'(lat), 32'd258);
        check("addr_second", 32'(last_addr), 32'h4);
`endif
        tick(3);
        fetch_and_wait(w, lat);
        check("word_third", w, 32'h0809_0A0B);
`ifndef FLASH_CONT_READ_EN
        check("addr_third", 32'(last_addr), 32'h8);
`endif

        // Extra fetch pulse while the engine is shifting data must be dropped.
        tick(10);
        fetch_en = 1'b1;
        tick(1);
        fetch_en = 1'b0;
`ifdef FLASH_CONT_READ_EN
        tick(60);
`else
        tick(150);
`endif
        fetch_en = 1'b1;
        tick(1);
        fetch_en = 1'b0;
        n = 0;
        repeat (400) begin
            @(negedge clk);
            if (word_ready) begin
                n++;
                w = word;
            end
        end
        check("busy_fetch_ignored", 32'(n), 32'd1);
        check("word_fourth", w, 32'h0C0D_0E0F);

        // Bypass mid-ADDR
        tick(1);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        fetch_en = 1'b1;
        tick(1);
        fetch_en = 1'b0;
        tick(80);
        bypass_en = 1'b1;
        host_mosi = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bypass_mirror", 32'(flash_mosi), 32'(host_mosi));
            if (word_ready) n++;
            if (i > 0) begin
                check("bypass_csb", 32'(flash_csb), 32'h1);
                check("bypass_sclk", 32'(flash_clk), 32'h0);
            end
            tick(1);
            host_mosi = ~host_mosi;
        end
        bypass_en = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (word_ready) n++;
        end
        check("abort_no_word", 32'(n), 32'd0);
        fetch_and_wait(w, lat);
        check("lat_after_bypass", 32'(lat), 32'd258);
        check("word_after_bypass", w, 32'h0001_0203);
        check("addr_after_bypass", 32'(last_addr), 32'h0);

        // Asynchronous reset in the middle of DATA
        tick(10);
        fetch_en = 1'b1;
        tick(1);
        fetch_en = 1'b0;
        tick(200);
        #1 reset = 1'b0;
        #1;
        check("arst_csb", 32'(flash_csb), 32'h1);
        check("arst_sclk", 32'(flash_clk), 32'h0);
        check("arst_word", word, 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        tick(3);
        reset = 1'b1;
        tick(2);
        fetch_and_wait(w, lat);
        check("word_after_reset", w, 32'h0001_0203);
        check("addr_after_reset", 32'(last_addr), 32'h0);

        // Randomized fetch / bypass traffic checked by the transaction model
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: tick(int'($urandom_range(1, 300)));
                1: begin
                    fetch_en = 1'b1;
                    tick(1);
                    fetch_en = 1'b0;
                    tick(int'($urandom_range(1, 300)));
                end
                2: begin
                    fetch_en = 1'b1;
                    tick(int'($urandom_range(200, 700)));
                    fetch_en = 1'b0;
                end
                default: begin
                    bypass_en = 1'b1;
                    repeat (int'($urandom_range(1, 5))) begin
                        host_mosi = 1'($urandom_range(0, 1));
                        tick(1);
                    end
                    bypass_en = 1'b0;
                end
            endcase
        end
        tick(700);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
